// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// opcode values, opcode class fields and the decoded-class bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // The class field sits in the top two opcode bits.
  localparam int CLS_HI = 4;
  localparam int CLS_LO = 3;
  localparam logic [1:0] CLS_R = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;

  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  localparam logic [4:0] OP_BEQ   = 5'b11000;
  localparam logic [4:0] OP_JUMP  = 5'b11001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_beq;
    logic is_jmp;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational one-hot classification of a 5-bit OpFn into instruction classes.
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [4:0] op,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    if (op[CLS_HI:CLS_LO] == CLS_R)      cls.is_r       = 1'b1;
    else if (op[CLS_HI:CLS_LO] == CLS_I) cls.is_i       = 1'b1;
    else if (op == OP_LOAD)              cls.is_ld      = 1'b1;
    else if (op == OP_STORE)             cls.is_st      = 1'b1;
    else if (op == OP_BEQ)               cls.is_beq     = 1'b1;
    else if (op == OP_JUMP)              cls.is_jmp     = 1'b1;
    else if (op == OP_HALT)              cls.is_halt    = 1'b1;
    else                                 cls.is_illegal = 1'b1;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB strobes, run/halt
// control, sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [4:0]       OpFn,
  input  logic             alubeq,
  output logic             NIA,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       ALUFn,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemToReg,
  output logic             branch_taken,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  state_e            state_q, state_d, after_instr;
  logic [4:0]        op_q, op_d, op_sel;
  logic              illegal_q, illegal_d;
  logic              run_q, run_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  op_class_t         cls;

  // DECODE looks at the live opcode; every later state uses the latched copy.
  assign op_sel = (state_q == S_DECODE) ? OpFn : op_q;

  opcode_classifier u_classifier (
    .op  (op_sel),
    .cls (cls)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    illegal_d    = illegal_q;
    run_d        = run;
    NIA          = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    ALUFn        = 3'b000;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    MemToReg     = 1'b0;
    branch_taken = 1'b0;
    after_instr  = run ? S_FETCH : S_IDLE;

    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (cls.is_r || cls.is_i) begin
          ALUFn  = op_sel[2:0];
          ALUSrc = cls.is_i;
          RegDst = cls.is_r;
        end
        if (cls.is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
          op_d    = OpFn;
        end
      end
      S_EXEC: begin
        if (cls.is_r || cls.is_i) begin
          ALUFn   = op_sel[2:0];
          ALUSrc  = cls.is_i;
          RegDst  = cls.is_r;
          state_d = S_WB;
        end else if (cls.is_ld || cls.is_st) begin
          ALUFn   = ALU_ADD;
          ALUSrc  = 1'b1;
          state_d = S_MEM;
        end else if (cls.is_beq) begin
          ALUFn        = ALU_SUB;
          NIA          = 1'b1;
          branch_taken = alubeq;
          state_d      = after_instr;
        end else if (cls.is_jmp) begin
          NIA          = 1'b1;
          branch_taken = 1'b1;
          state_d      = after_instr;
        end else if (cls.is_illegal) begin
          NIA       = 1'b1;
          illegal_d = 1'b1;
          state_d   = after_instr;
        end else begin
          state_d = after_instr;
        end
      end
      S_MEM: begin
        // Address stays on the ALU while memory is accessed.
        ALUFn  = ALU_ADD;
        ALUSrc = 1'b1;
        if (cls.is_ld) begin
          MemRead = 1'b1;
          state_d = S_WB;
        end else begin
          MemWrite = 1'b1;
          NIA      = 1'b1;
          state_d  = after_instr;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        NIA      = 1'b1;
        state_d  = after_instr;
        if (cls.is_ld) begin
          MemRead  = 1'b1;
          MemToReg = 1'b1;
        end else begin
          ALUFn  = op_sel[2:0];
          ALUSrc = cls.is_i;
          RegDst = cls.is_r;
        end
      end
      // Only a fresh run edge restarts; the PC still points at the HALT word.
      S_HALT:  if (run && !run_q) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q + CNT_W'(NIA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      run_q     <= run_d;
      retired_q <= retired_d;
    end
  end

  assign illegal   = illegal_q;
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule
